a_net2pp_rx: RTL and testbench

Alice-side receive front end that sits directly upstream of Alice's RX unpacket stage. It accepts one B2A packet per transfer as a 32-bit word stream from the network interface and writes it into the RX BRAM on port A: header at address 0, payload from address 1. It validates the word count against the header length code, then hands the packet to the unpacket stage over the msg_accessed / busy handshake. The BRAM is never overwritten until the unpacket stage releases it.

---
 rtl/a_net2pp_rx_pkg.sv | 55 +++++
 rtl/a_net2pp_rx_fsm.sv | 89 ++++++++
 rtl/a_net2pp_rx.sv | 106 ++++++++++
 tb/tb_a_net2pp_rx.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a_net2pp_rx_pkg.sv
// rtl/a_net2pp_rx_pkg.sv - shared B2A header fields, length codes, state encoding and length helper
package a_net2pp_rx_pkg;

    localparam int MAX_WORDS = 1025;
    localparam int ADDR_W    = 11;

    localparam int TYPE_MSB = 31;
    localparam int TYPE_LSB = 28;
    localparam int LEN_MSB  = 27;
    localparam int LEN_LSB  = 24;
    localparam int SLEN_MSB = 23;
    localparam int SLEN_LSB = 15;

    localparam logic [3:0] PKT_TYPE_DATA = 4'h1;
    localparam logic [3:0] PKT_TYPE_CTRL = 4'h2;

    localparam logic [3:0] LEN_CODE_257  = 4'h1;
    localparam logic [3:0] LEN_CODE_514  = 4'h2;
    localparam logic [3:0] LEN_CODE_771  = 4'h3;
    localparam logic [3:0] LEN_CODE_1028 = 4'h4;

    localparam logic [ADDR_W-1:0] WORDS_514  = 11'd513;
    localparam logic [ADDR_W-1:0] WORDS_771  = 11'd769;
    localparam logic [ADDR_W-1:0] WORDS_1028 = 11'd1025;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RECEIVE = 4'd1,
        ST_COMMIT  = 4'd2,
        ST_NOTIFY  = 4'd3,
        ST_RELEASE = 4'd4,
        ST_DROP    = 4'd5
    } rx_state_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] words;
    } len_exp_t;

    // Total BRAM words (header included) implied by a header length code.
    function automatic len_exp_t expected_words(input logic [3:0] code, input logic [8:0] short_len);
        len_exp_t r;
        r.valid = 1'b1;
        r.words = '0;
        case (code)
            LEN_CODE_257:  r.words = {2'b00, short_len} + 11'd1;
            LEN_CODE_514:  r.words = WORDS_514;
            LEN_CODE_771:  r.words = WORDS_771;
            LEN_CODE_1028: r.words = WORDS_1028;
            default:       r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/a_net2pp_rx_fsm.sv
// rtl/a_net2pp_rx_fsm.sv - receive/commit/handoff state machine for the B2A receive front end
module a_net2pp_rx_fsm
    import a_net2pp_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic       rx_last,
    input  logic       wcnt_last,
    input  logic       len_ok,
    input  logic       busy_pp2net,
    output logic [3:0] state,
    output logic       rx_ready,
    output logic       accept,
    output logic       busy_net,
    output logic       msg_accessed,
    output logic       commit_ok,
    output logic       len_fail,
    output logic       release_done
);

    rx_state_e st, st_next;
    logic      ready_st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= ST_IDLE;
            busy_net     <= 1'b0;
            msg_accessed <= 1'b0;
        end else begin
            st           <= st_next;
            busy_net     <= (st_next == ST_RECEIVE) || (st_next == ST_COMMIT) || (st_next == ST_DROP);
            msg_accessed <= (st_next == ST_NOTIFY);
        end
    end

    always_comb begin
        st_next      = st;
        ready_st     = 1'b0;
        commit_ok    = 1'b0;
        len_fail     = 1'b0;
        release_done = 1'b0;
        case (st)
            ST_IDLE: begin
                ready_st = 1'b1;
                if (rx_valid) st_next = rx_last ? ST_COMMIT : ST_RECEIVE;
            end
            ST_RECEIVE: begin
                ready_st = 1'b1;
                if (rx_valid) begin
                    if (rx_last)        st_next = ST_COMMIT;
                    else if (wcnt_last) st_next = ST_DROP;
                end
            end
            ST_COMMIT: begin
                if (len_ok) begin
                    commit_ok = 1'b1;
                    st_next   = ST_NOTIFY;
                end else begin
                    len_fail  = 1'b1;
                    st_next   = ST_IDLE;
                end
            end
            ST_NOTIFY: begin
                if (busy_pp2net) st_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!busy_pp2net) begin
                    release_done = 1'b1;
                    st_next      = ST_IDLE;
                end
            end
            ST_DROP: begin
                ready_st = 1'b1;
                if (rx_valid && rx_last) begin
                    len_fail = 1'b1;
                    st_next  = ST_IDLE;
                end
            end
            default: st_next = ST_IDLE;
        endcase
    end

    // Not ready while held in reset so every output reads 0 during reset.
    assign rx_ready = ready_st & rst_n;
    assign accept   = rx_valid & rx_ready;
    assign state    = st;

endmodule

// File: rtl/a_net2pp_rx.sv
// rtl/a_net2pp_rx.sv - B2A packet receive front end writing the RX BRAM and handing off to unpacket
module a_net2pp_rx
    import a_net2pp_rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [31:0]       rx_data,
    input  logic              rx_last,
    output logic              rx_ready,
    output logic              A_RX_bram_clka,
    output logic              A_RX_bram_ena,
    output logic              A_RX_bram_wea,
    output logic [ADDR_W-1:0] A_RX_bram_addra,
    output logic [31:0]       A_RX_bram_dina,
    output logic              msg_accessed,
    output logic              busy_Net2PP_RX,
    output logic [ADDR_W-1:0] sizeRX_msg,
    input  logic              busy_PP2Net_RX,
    output logic              err_len,
    output logic [15:0]       pkt_ok_cnt,
    output logic [15:0]       pkt_drop_cnt,
    output logic [3:0]        A_rx_state
);

    logic [3:0]        state;
    logic              accept;
    logic              wcnt_last;
    logic              len_ok;
    logic              commit_ok;
    logic              len_fail;
    logic              release_done;
    logic [ADDR_W-1:0] wcnt;
    logic [3:0]        hdr_len_code;
    logic [8:0]        hdr_short_len;
    len_exp_t          exp_len;

    a_net2pp_rx_fsm u_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_valid     (rx_valid),
        .rx_last      (rx_last),
        .wcnt_last    (wcnt_last),
        .len_ok       (len_ok),
        .busy_pp2net  (busy_PP2Net_RX),
        .state        (state),
        .rx_ready     (rx_ready),
        .accept       (accept),
        .busy_net     (busy_Net2PP_RX),
        .msg_accessed (msg_accessed),
        .commit_ok    (commit_ok),
        .len_fail     (len_fail),
        .release_done (release_done)
    );

    assign exp_len   = expected_words(hdr_len_code, hdr_short_len);
    assign len_ok    = exp_len.valid && (wcnt == exp_len.words);
    // The beat now being written is the last one that still fits in the BRAM.
    assign wcnt_last = (wcnt == ADDR_W'(MAX_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt            <= '0;
            hdr_len_code    <= '0;
            hdr_short_len   <= '0;
            A_RX_bram_wea   <= 1'b0;
            A_RX_bram_addra <= '0;
            A_RX_bram_dina  <= '0;
            sizeRX_msg      <= '0;
            err_len         <= 1'b0;
            pkt_ok_cnt      <= '0;
            pkt_drop_cnt    <= '0;
        end else begin
            A_RX_bram_wea <= 1'b0;
            err_len       <= len_fail;
            if (accept && state == ST_IDLE) begin
                hdr_len_code    <= rx_data[LEN_MSB:LEN_LSB];
                hdr_short_len   <= rx_data[SLEN_MSB:SLEN_LSB];
                A_RX_bram_wea   <= 1'b1;
                A_RX_bram_addra <= '0;
                A_RX_bram_dina  <= rx_data;
                wcnt            <= ADDR_W'(1);
            end else if (accept && state == ST_RECEIVE) begin
                A_RX_bram_wea   <= 1'b1;
                A_RX_bram_addra <= wcnt;
                A_RX_bram_dina  <= rx_data;
                wcnt            <= wcnt + ADDR_W'(1);
            end
            if (commit_ok) sizeRX_msg <= wcnt;
            if (len_fail) begin
                wcnt <= '0;
                if (pkt_drop_cnt != 16'hFFFF) pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
            end
            if (release_done) begin
                wcnt       <= '0;
                sizeRX_msg <= '0;
                if (pkt_ok_cnt != 16'hFFFF) pkt_ok_cnt <= pkt_ok_cnt + 16'd1;
            end
        end
    end

    assign A_RX_bram_clka = clk;
    assign A_RX_bram_ena  = 1'b1;
    assign A_rx_state     = state;

endmodule

// File: tb/tb_a_net2pp_rx.sv
// tb/tb_a_net2pp_rx.sv - randomized self-checking bench for a_net2pp_rx
module tb_a_net2pp_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_last = 1'b0;
    logic        busy_PP2Net_RX = 1'b0;
    logic        rx_ready;
    logic        A_RX_bram_clka, A_RX_bram_ena, A_RX_bram_wea;
    logic [10:0] A_RX_bram_addra;
    logic [31:0] A_RX_bram_dina;
    logic        msg_accessed, busy_Net2PP_RX, err_len;
    logic [10:0] sizeRX_msg;
    logic [15:0] pkt_ok_cnt, pkt_drop_cnt;
    logic [3:0]  A_rx_state;

    a_net2pp_rx dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .rx_last         (rx_last),
        .rx_ready        (rx_ready),
        .A_RX_bram_clka  (A_RX_bram_clka),
        .A_RX_bram_ena   (A_RX_bram_ena),
        .A_RX_bram_wea   (A_RX_bram_wea),
        .A_RX_bram_addra (A_RX_bram_addra),
        .A_RX_bram_dina  (A_RX_bram_dina),
        .msg_accessed    (msg_accessed),
        .busy_Net2PP_RX  (busy_Net2PP_RX),
        .sizeRX_msg      (sizeRX_msg),
        .busy_PP2Net_RX  (busy_PP2Net_RX),
        .err_len         (err_len),
        .pkt_ok_cnt      (pkt_ok_cnt),
        .pkt_drop_cnt    (pkt_drop_cnt),
        .A_rx_state      (A_rx_state)
    );

    always #5 clk = ~clk;

    typedef struct { longint t; logic [10:0] addr; logic [31:0] data; } wr_t;
    typedef struct { longint t; logic [31:0] data; } acc_t;

    wr_t  wr_q[$];
    acc_t acc_q[$];
    wr_t  mon_w;
    int   err_pulses = 0;
    int   msg_cycles = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   ok_exp = 0;
    int   drop_exp = 0;

    always @(negedge clk) begin
        if (A_RX_bram_wea === 1'b1) begin
            mon_w.t    = longint'($time);
            mon_w.addr = A_RX_bram_addra;
            mon_w.data = A_RX_bram_dina;
            wr_q.push_back(mon_w);
        end
        if (err_len === 1'b1) err_pulses++;
        if (msg_accessed === 1'b1) msg_cycles++;
    end

    function automatic logic [31:0] mk_hdr(input logic [3:0] code, input logic [8:0] slen);
        logic [14:0] r;
        r = 15'($urandom);
        return {4'h1, code, slen, r};
    endfunction

    function automatic void mk_words(input logic [31:0] hdr, input int n, output logic [31:0] q[$]);
        q = {};
        q.push_back(hdr);
        for (int i = 1; i < n; i++) q.push_back($urandom);
    endfunction

    // Reference: delivered only if the total word count matches the header's length code and fits.
    function automatic bit model_deliver(input logic [31:0] hdr, input int n);
        int exp_n;
        case (hdr[27:24])
            4'h1:    exp_n = int'(hdr[23:15]) + 1;
            4'h2:    exp_n = 513;
            4'h3:    exp_n = 769;
            4'h4:    exp_n = 1025;
            default: exp_n = -1;
        endcase
        return (n <= 1025) && (n == exp_n);
    endfunction

    task automatic send(input logic [31:0] w[$], input bit last_on_end);
        acc_t a;
        int   t;
        for (int i = 0; i < w.size(); i++) begin
            rx_valid = 1'b1;
            rx_data  = w[i];
            rx_last  = last_on_end && (i == w.size() - 1);
            t = 0;
            while (rx_ready !== 1'b1 && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (rx_ready !== 1'b1) begin
                tests_run++;
                tests_failed++;
                $display("FAIL send_timeout beat %0d: rx_ready=%b required 1", i, rx_ready);
                rx_valid = 1'b0;
                rx_last  = 1'b0;
                return;
            end
            a.t    = longint'($time);
            a.data = w[i];
            acc_q.push_back(a);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    task automatic do_packet(input logic [31:0] w[$]);
        int n, e0, m0, nw, t;
        bit deliver, bad;
        wr_q.delete();
        acc_q.delete();
        n       = w.size();
        deliver = model_deliver(w[0], n);
        e0      = err_pulses;
        m0      = msg_cycles;
        send(w, 1'b1);
        if (deliver) begin
            t = 0;
            while (msg_accessed !== 1'b1 && t < 20) begin
                @(negedge clk);
                t++;
            end
            tests_run++;
            if (msg_accessed !== 1'b1 || busy_Net2PP_RX !== 1'b0 || A_rx_state !== 4'd3) begin
                tests_failed++;
                $display("FAIL notify n=%0d: msg=%b busy=%b state=%0d required 1 0 3", n, msg_accessed, busy_Net2PP_RX, A_rx_state);
            end
            tests_run++;
            if (sizeRX_msg !== 11'(n)) begin
                tests_failed++;
                $display("FAIL size: sizeRX_msg=%0d required %0d", sizeRX_msg, n);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            busy_PP2Net_RX = 1'b1;
            repeat ($urandom_range(1, 8)) @(negedge clk);
            tests_run++;
            if (msg_accessed !== 1'b0 || A_rx_state !== 4'd4 || rx_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL release: msg=%b state=%0d ready=%b required 0 4 0", msg_accessed, A_rx_state, rx_ready);
            end
            busy_PP2Net_RX = 1'b0;
            ok_exp++;
            repeat (2) @(negedge clk);
        end else begin
            repeat (4) @(negedge clk);
            drop_exp++;
            tests_run++;
            if (err_pulses - e0 != 1) begin
                tests_failed++;
                $display("FAIL err_len n=%0d: pulse cycles=%0d required 1", n, err_pulses - e0);
            end
        end
        tests_run++;
        if (deliver ? (msg_cycles == m0) : (msg_cycles != m0)) begin
            tests_failed++;
            $display("FAIL msg_cycles n=%0d: got %0d cycles, deliver=%0d", n, msg_cycles - m0, deliver);
        end
        nw  = (n < 1025) ? n : 1025;
        bad = (wr_q.size() != nw) || (acc_q.size() != n);
        if (!bad) begin
            for (int k = 0; k < nw; k++) begin
                if (wr_q[k].addr != 11'(k) || wr_q[k].data != w[k] || wr_q[k].t != acc_q[k].t + 10) bad = 1'b1;
            end
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL writes n=%0d: got %0d writes/%0d accepts, required %0d/%0d in order one cycle after beat", n, wr_q.size(), acc_q.size(), nw, n);
        end
        tests_run++;
        if (pkt_ok_cnt !== 16'(ok_exp) || pkt_drop_cnt !== 16'(drop_exp) || A_rx_state !== 4'd0) begin
            tests_failed++;
            $display("FAIL counters: ok=%0d drop=%0d state=%0d required %0d %0d 0", pkt_ok_cnt, pkt_drop_cnt, A_rx_state, ok_exp, drop_exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (rx_ready !== 1'b0 || A_rx_state !== 4'd0 || A_RX_bram_wea !== 1'b0 || msg_accessed !== 1'b0 ||
            busy_Net2PP_RX !== 1'b0 || err_len !== 1'b0 || pkt_ok_cnt !== 16'd0 || pkt_drop_cnt !== 16'd0 ||
            sizeRX_msg !== 11'd0 || A_RX_bram_addra !== 11'd0 || A_RX_bram_dina !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ready=%b state=%0d wea=%b msg=%b busy=%b ok=%0d drop=%0d required all 0",
                     rx_ready, A_rx_state, A_RX_bram_wea, msg_accessed, busy_Net2PP_RX, pkt_ok_cnt, pkt_drop_cnt);
        end
        tests_run++;
        if (A_RX_bram_ena !== 1'b1 || A_RX_bram_clka !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ties: ena=%b clka=%b required 1 0 (clk low)", A_RX_bram_ena, A_RX_bram_clka);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (rx_ready !== 1'b1 || A_rx_state !== 4'd0) begin
            tests_failed++;
            $display("FAIL idle_ready: ready=%b state=%0d required 1 0", rx_ready, A_rx_state);
        end
    endtask

    task automatic test_short_pkt();
        logic [31:0] w[$];
        mk_words(mk_hdr(4'h1, 9'd5), 6, w);
        do_packet(w);
    endtask

    task automatic test_random();
        logic [31:0] w[$];
        int r, n, sl;
        for (int p = 0; p < 10; p++) begin
            r = $urandom_range(0, 9);
            if (r <= 6) begin
                sl = $urandom_range(0, 40);
                n  = sl + 1 + $urandom_range(0, 2) - 1;
                if (n < 1) n = 1;
                mk_words(mk_hdr(4'h1, 9'(sl)), n, w);
            end else if (r == 7) begin
                mk_words(mk_hdr(4'h3, 9'($urandom)), 769, w);
            end else if (r == 8) begin
                mk_words(mk_hdr(4'(4'h5 + $urandom_range(0, 10)), 9'($urandom)), $urandom_range(1, 4), w);
            end else begin
                mk_words(mk_hdr(4'h2, 9'($urandom)), 513 + $urandom_range(0, 1), w);
            end
            do_packet(w);
        end
    endtask

    task automatic test_514();
        logic [31:0] w[$];
        mk_words(mk_hdr(4'h2, 9'd0), 513, w);
        do_packet(w);
        mk_words(mk_hdr(4'h2, 9'd0), 512, w);
        do_packet(w);
    endtask

    task automatic test_bad_code();
        logic [31:0] w[$];
        mk_words(mk_hdr(4'hF, 9'd0), 1, w);
        do_packet(w);
    endtask

    task automatic test_overflow();
        logic [31:0] w[$];
        logic [31:0] part1[$];
        logic [31:0] part2[$];
        int e0;
        bit bad;
        mk_words(mk_hdr(4'h4, 9'd0), 1030, w);
        part1 = w[0:1024];
        part2 = w[1025:1029];
        wr_q.delete();
        acc_q.delete();
        e0 = err_pulses;
        send(part1, 1'b0);
        tests_run++;
        if (A_rx_state !== 4'd5 || rx_ready !== 1'b1 || busy_Net2PP_RX !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_drop_entry: state=%0d ready=%b busy=%b required 5 1 1", A_rx_state, rx_ready, busy_Net2PP_RX);
        end
        send(part2, 1'b1);
        repeat (3) @(negedge clk);
        drop_exp++;
        tests_run++;
        if (err_pulses - e0 != 1) begin
            tests_failed++;
            $display("FAIL overflow_err: pulse cycles=%0d required 1", err_pulses - e0);
        end
        bad = (wr_q.size() != 1025) || (acc_q.size() != 1030);
        if (!bad) bad = (wr_q[1024].addr != 11'd1024) || (wr_q[1024].data != w[1024]) ||
                        (wr_q[1024].t != acc_q[1024].t + 10) || (wr_q[0].data != w[0]);
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL overflow_writes: got %0d writes/%0d accepts required 1025/1030", wr_q.size(), acc_q.size());
        end
        tests_run++;
        if (pkt_drop_cnt !== 16'(drop_exp) || pkt_ok_cnt !== 16'(ok_exp) || A_rx_state !== 4'd0) begin
            tests_failed++;
            $display("FAIL overflow_counters: ok=%0d drop=%0d state=%0d required %0d %0d 0", pkt_ok_cnt, pkt_drop_cnt, A_rx_state, ok_exp, drop_exp);
        end
    endtask

    task automatic test_hold_busy();
        logic [31:0] w[$];
        logic [31:0] w2[$];
        int t, rdy, wcount0;
        longint t_drop;
        mk_words(mk_hdr(4'h1, 9'd3), 4, w);
        mk_words(mk_hdr(4'h1, 9'd2), 3, w2);
        wr_q.delete();
        acc_q.delete();
        send(w, 1'b1);
        t = 0;
        while (msg_accessed !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        tests_run++;
        if (msg_accessed !== 1'b1 || sizeRX_msg !== 11'd4) begin
            tests_failed++;
            $display("FAIL hold_notify: msg=%b size=%0d required 1 4", msg_accessed, sizeRX_msg);
        end
        busy_PP2Net_RX = 1'b1;
        rx_valid = 1'b1;
        rx_data  = w2[0];
        rx_last  = 1'b0;
        wcount0  = wr_q.size();
        rdy      = 0;
        repeat (50) begin
            @(negedge clk);
            if (rx_ready !== 1'b0) rdy++;
        end
        tests_run++;
        if (rdy != 0 || wr_q.size() != wcount0 || wcount0 != 4) begin
            tests_failed++;
            $display("FAIL hold_block: ready cycles=%0d writes=%0d->%0d required 0 and 4->4", rdy, wcount0, wr_q.size());
        end
        tests_run++;
        if (A_rx_state !== 4'd4 || pkt_ok_cnt !== 16'(ok_exp)) begin
            tests_failed++;
            $display("FAIL hold_state: state=%0d ok=%0d required 4 %0d", A_rx_state, pkt_ok_cnt, ok_exp);
        end
        busy_PP2Net_RX = 1'b0;
        t_drop = longint'($time);
        ok_exp++;
        do_packet(w2);
        tests_run++;
        if (acc_q.size() == 0 || acc_q[0].t <= t_drop) begin
            tests_failed++;
            $display("FAIL hold_late_accept: accepts=%0d first_t=%0d required after %0d", acc_q.size(), (acc_q.size() > 0) ? acc_q[0].t : 0, t_drop);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] w[$];
        logic [31:0] part[$];
        mk_words(mk_hdr(4'h1, 9'd10), 11, w);
        part = w[0:3];
        send(part, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        ok_exp   = 0;
        drop_exp = 0;
        tests_run++;
        if (A_rx_state !== 4'd0 || busy_Net2PP_RX !== 1'b0 || A_RX_bram_wea !== 1'b0 || rx_ready !== 1'b0 ||
            A_RX_bram_addra !== 11'd0 || pkt_ok_cnt !== 16'd0 || pkt_drop_cnt !== 16'd0 || msg_accessed !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: state=%0d busy=%b wea=%b ready=%b addr=%0d ok=%0d drop=%0d required all 0",
                     A_rx_state, busy_Net2PP_RX, A_RX_bram_wea, rx_ready, A_RX_bram_addra, pkt_ok_cnt, pkt_drop_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mk_words(mk_hdr(4'h1, 9'd3), 4, w);
        do_packet(w);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run + 1, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_short_pkt();
        test_514();
        test_bad_code();
        test_overflow();
        test_hold_busy();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
